// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one transfer in flight, round-robin
// read/write arbitration, one-hot pselx decode and an ACCESS timeout guard.
module axi_lite_apb_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [AW-1:0]   s_awaddr,
  input  logic [2:0]      s_awprot,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [DW-1:0]   s_wdata,
  input  logic [DW/8-1:0] s_wstrb,
  input  logic            s_wvalid,
  output logic            s_wready,
  output logic [1:0]      s_bresp,
  output logic            s_bvalid,
  input  logic            s_bready,
  input  logic [AW-1:0]   s_araddr,
  input  logic [2:0]      s_arprot,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [DW-1:0]   s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [AW-1:0]   m_paddr,
  output logic [2:0]      m_pprot,
  output logic [3:0]      m_pselx,
  output logic            m_penable,
  output logic            m_pwrite,
  output logic [DW-1:0]   m_pwdata,
  output logic [DW/8-1:0] m_pstrb,
  input  logic            m_pready,
  input  logic            m_pslverr,
  input  logic [DW-1:0]   m_prdata
);
  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic            pref_wr_q, pref_wr_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [2:0]      pprot_q, pprot_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [3:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      resp_q, resp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            gnt_wr, gnt_rd;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pref_wr_q <= 1'b1;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      resp_q    <= OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pref_wr_q <= pref_wr_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  // A write needs both address and data present; ties go to the preferred side.
  assign gnt_wr = (state_q == IDLE) && s_awvalid && s_wvalid && (pref_wr_q || !s_arvalid);
  assign gnt_rd = (state_q == IDLE) && s_arvalid && !gnt_wr;

  always_comb begin
    state_d   = state_q;
    pref_wr_d = pref_wr_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_wr) begin
          paddr_d   = s_awaddr;
          pprot_d   = s_awprot;
          pwrite_d  = 1'b1;
          pwdata_d  = s_wdata;
          pstrb_d   = s_wstrb;
          sel_d     = 4'b0001 << s_awaddr[SEL_LSB +: 2];
          cnt_d     = '0;
          pref_wr_d = !pref_wr_q;
          state_d   = SETUP;
        end else if (gnt_rd) begin
          paddr_d   = s_araddr;
          pprot_d   = s_arprot;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          pstrb_d   = '0;
          sel_d     = 4'b0001 << s_araddr[SEL_LSB +: 2];
          cnt_d     = '0;
          pref_wr_d = !pref_wr_q;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          resp_d  = m_pslverr ? SLVERR : OKAY;
          if (!pwrite_q) rdata_d = m_prdata;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Slave never answered: give up so the AXI side is not hung.
          resp_d  = SLVERR;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (pwrite_q ? s_bready : s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_awready = gnt_wr;
  assign s_wready  = gnt_wr;
  assign s_arready = gnt_rd;
  assign s_bvalid  = (state_q == RESP) && pwrite_q;
  assign s_rvalid  = (state_q == RESP) && !pwrite_q;
  assign s_bresp   = resp_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;
  assign m_paddr   = paddr_q;
  assign m_pprot   = pprot_q;
  assign m_pwrite  = pwrite_q;
  assign m_pwdata  = pwdata_q;
  assign m_pstrb   = pstrb_q;
  assign m_pselx   = (state_q == SETUP || state_q == ACCESS) ? sel_q : 4'b0000;
  assign m_penable = (state_q == ACCESS);
endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Directed bench for axi_lite_apb_bridge with hand-computed expectations.
module tb_axi_lite_apb_bridge;
  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic [2:0]  m_pprot;
  logic [3:0]  m_pselx, m_pstrb;
  logic        m_penable, m_pwrite, m_pready, m_pslverr;
  logic        outs_or;
  int          n_chk = 0, n_fail = 0;
  logic [3:0]  exp_w;

  axi_lite_apb_bridge #(.AW(32), .DW(32), .SEL_LSB(12), .TIMEOUT(4)) dut (
    .clock(clock), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_paddr(m_paddr), .m_pprot(m_pprot), .m_pselx(m_pselx), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  always #5 clock = ~clock;

  assign outs_or = |{s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
                     s_rvalid, m_paddr, m_pprot, m_pselx, m_penable, m_pwrite, m_pwdata, m_pstrb};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    #12;
    chk("rst_outs", 64'(outs_or), 64'd0);
    resetn = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog tests=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    m_pready = 0; m_pslverr = 0; m_prdata = '0;
    do_reset();

    // 1: write, zero wait states
    s_awaddr = 32'h0000_1004; s_awprot = 3'b010; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; m_pready = 1;
    #1;
    chk("t1_awready", 64'(s_awready), 64'd1);
    chk("t1_wready", 64'(s_wready), 64'd1);
    chk("t1_arready", 64'(s_arready), 64'd0);
    chk("t1_sel_c0", 64'(m_pselx), 64'd0);
    step(); s_awvalid = 0; s_wvalid = 0;
    chk("t1_sel_setup", 64'(m_pselx), 64'h2);
    chk("t1_pen_setup", 64'(m_penable), 64'd0);
    chk("t1_paddr", 64'(m_paddr), 64'h1004);
    chk("t1_pwdata", 64'(m_pwdata), 64'hDEADBEEF);
    chk("t1_pstrb", 64'(m_pstrb), 64'hF);
    chk("t1_pwrite", 64'(m_pwrite), 64'd1);
    chk("t1_pprot", 64'(m_pprot), 64'd2);
    step();
    chk("t1_pen_access", 64'(m_penable), 64'd1);
    chk("t1_sel_access", 64'(m_pselx), 64'h2);
    chk("t1_bvalid_c2", 64'(s_bvalid), 64'd0);
    step();
    chk("t1_bvalid", 64'(s_bvalid), 64'd1);
    chk("t1_bresp", 64'(s_bresp), 64'd0);
    chk("t1_pen_resp", 64'(m_penable), 64'd0);
    chk("t1_sel_resp", 64'(m_pselx), 64'd0);
    s_bready = 1;
    step(); s_bready = 0;
    chk("t1_bvalid_done", 64'(s_bvalid), 64'd0);

    // 2: read with 3 wait states
    m_pready = 0; s_araddr = 32'h0000_3000; s_arvalid = 1;
    #1;
    chk("t2_arready", 64'(s_arready), 64'd1);
    step(); s_arvalid = 0;
    chk("t2_sel", 64'(m_pselx), 64'h8);
    chk("t2_pstrb", 64'(m_pstrb), 64'd0);
    chk("t2_pwrite", 64'(m_pwrite), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_pen_wait", 64'(m_penable), 64'd1);
      chk("t2_rvalid_wait", 64'(s_rvalid), 64'd0);
    end
    m_pready = 1; m_prdata = 32'h1234_5678;
    step();
    chk("t2_rvalid", 64'(s_rvalid), 64'd1);
    chk("t2_rdata", 64'(s_rdata), 64'h12345678);
    chk("t2_rresp", 64'(s_rresp), 64'd0);
    chk("t2_pen_resp", 64'(m_penable), 64'd0);
    s_rready = 1;
    step(); s_rready = 0;
    chk("t2_rvalid_done", 64'(s_rvalid), 64'd0);

    // 3: contested arbitration from reset -> W,R,W,R
    do_reset();
    s_awaddr = 32'h0; s_wdata = 32'h11; s_araddr = 32'h1000;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_pready = 1; s_bready = 1; s_rready = 1;
    exp_w = 4'b0101;
    #1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!(s_awready || s_arready) && n < 10) begin
        step();
        n++;
      end
      chk("t3_grant_seen", 64'(n < 10), 64'd1);
      chk("t3_grant_wr", 64'(s_awready), 64'(exp_w[i]));
      chk("t3_grant_excl", 64'(s_awready & s_arready), 64'd0);
      step();
      if (i == 3) begin s_wvalid = 0; s_arvalid = 0; end
    end
    step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_lone_aw", 64'(s_awready), 64'd0);
      chk("t3_lone_w", 64'(s_wready), 64'd0);
      step();
    end
    s_awvalid = 0; s_bready = 0; s_rready = 0;

    // 4: slave error with back-pressured B channel
    s_awaddr = 32'h0000_2000; s_awvalid = 1; s_wvalid = 1; m_pslverr = 1;
    #1;
    chk("t4_awready", 64'(s_awready), 64'd1);
    step(); s_awvalid = 0; s_wvalid = 0;
    step(); step();
    s_araddr = 32'h0; s_arvalid = 1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid_hold", 64'(s_bvalid), 64'd1);
      chk("t4_bresp_hold", 64'(s_bresp), 64'h2);
      chk("t4_arready_blk", 64'(s_arready), 64'd0);
      step();
    end
    s_arvalid = 0; s_bready = 1; m_pslverr = 0;
    step(); s_bready = 0;
    chk("t4_bvalid_done", 64'(s_bvalid), 64'd0);

    // 5: dead slave, timeout after 4 ACCESS cycles
    m_pready = 0; s_araddr = 32'h0000_0004; s_arvalid = 1;
    #1;
    chk("t5_arready", 64'(s_arready), 64'd1);
    step(); s_arvalid = 0;
    chk("t5_sel", 64'(m_pselx), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_pen_access", 64'(m_penable), 64'd1);
      chk("t5_sel_access", 64'(m_pselx), 64'h1);
    end
    step();
    chk("t5_sel_drop", 64'(m_pselx), 64'd0);
    chk("t5_pen_drop", 64'(m_penable), 64'd0);
    chk("t5_rvalid", 64'(s_rvalid), 64'd1);
    chk("t5_rresp", 64'(s_rresp), 64'h2);
    chk("t5_rdata", 64'(s_rdata), 64'd0);
    s_rready = 1;
    step(); s_rready = 0;

    // 6: reset during ACCESS, then a clean read
    s_araddr = 32'h0000_1000; s_arvalid = 1;
    #1;
    step(); s_arvalid = 0;
    step();
    chk("t6_in_access", 64'(m_penable), 64'd1);
    #2 resetn = 0;
    #1;
    chk("t6_async_clear", 64'(outs_or), 64'd0);
    m_pready = 1; s_rready = 1; s_bready = 1;
    step(); step();
    #3 resetn = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_rvalid", 64'(s_rvalid), 64'd0);
      chk("t6_no_bvalid", 64'(s_bvalid), 64'd0);
      chk("t6_no_sel", 64'(m_pselx), 64'd0);
    end
    s_rready = 0; s_bready = 0;
    s_araddr = 32'h0000_2008; m_prdata = 32'hCAFE_F00D; s_arvalid = 1;
    #1;
    chk("t6_arready", 64'(s_arready), 64'd1);
    step(); s_arvalid = 0;
    chk("t6_sel", 64'(m_pselx), 64'h4);
    step(); step();
    chk("t6_rvalid", 64'(s_rvalid), 64'd1);
    chk("t6_rdata", 64'(s_rdata), 64'hCAFEF00D);
    chk("t6_rresp", 64'(s_rresp), 64'd0);
    s_rready = 1;
    step(); s_rready = 0;
    chk("t6_rvalid_done", 64'(s_rvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
